sub_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one W-bit ripple subtractor among N_REQ requesters. Each request is granted, its operands are latched and subtracted, and the result is returned with the requester's id. It sits between the small-automation control units and the shared subtraction datapath, so there is one subtractor instance per cluster instead of one per unit.

---
 rtl/sub_arb_pkg.sv | 25 ++
 rtl/sub_arbiter_if.sv | 41 ++++
 rtl/sub_core.sv | 32 +++
 rtl/sub_arbiter.sv | 135 +++++++++++++
 tb/tb_sub_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sub_arb_pkg.sv
// -----------------------------------------------------------------------------
// sub_arb_pkg
// Shared definitions for the round-robin subtractor arbiter cluster.
//   state_t    : sequencer states (IDLE, CALC, RESP)
//   N_REQ_DEF  : default number of requesters
//   W_DEF      : default operand/result width
//   id_w()     : width of a requester index, clog2(N_REQ) with a floor of 1
// -----------------------------------------------------------------------------
package sub_arb_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int W_DEF     = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    // A single requester still needs a one-bit id field.
    function automatic int id_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sub_arbiter_if.sv
// -----------------------------------------------------------------------------
// sub_arbiter_if
// Bundles the requester-side handshake and the shared response bus.
//   req       : per-requester request level        (master -> slave)
//   a_in/b_in : packed operands, requester i at [i*W +: W] (master -> slave)
//   gnt       : one-hot grant pulse                (slave -> master)
//   D/Cout    : registered difference and carry    (slave -> master)
//   rsp_valid : response strobe                    (slave -> master)
//   rsp_id    : owner of the response              (slave -> master)
//   busy      : sequencer not idle                 (slave -> master)
// Modports: master = requester cluster, slave = arbiter.
// -----------------------------------------------------------------------------
interface sub_arbiter_if
    import sub_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int W     = W_DEF
);
    localparam int ID_W = id_w(N_REQ);

    logic [N_REQ-1:0]   req;
    logic [N_REQ*W-1:0] a_in;
    logic [N_REQ*W-1:0] b_in;
    logic [N_REQ-1:0]   gnt;
    logic [W-1:0]       D;
    logic               Cout;
    logic               rsp_valid;
    logic [ID_W-1:0]    rsp_id;
    logic               busy;

    modport master (
        output req, a_in, b_in,
        input  gnt, D, Cout, rsp_valid, rsp_id, busy
    );

    modport slave (
        input  req, a_in, b_in,
        output gnt, D, Cout, rsp_valid, rsp_id, busy
    );

endinterface

// File: rtl/sub_core.sv
// -----------------------------------------------------------------------------
// sub_core
// Combinational W-bit subtractor: a ripple of full adders computing
// a + ~b + 1.
//   a, b : operands (minuend, subtrahend)
//   d    : difference modulo 2^W
//   cout : carry out of the top bit; 1 means no borrow (a >= b)
// -----------------------------------------------------------------------------
module sub_core #(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] d,
    output logic         cout
);

    logic [W:0]   carry;
    logic [W-1:0] b_inv;

    // The +1 of the two's-complement negation enters as the carry-in.
    assign carry[0] = 1'b1;
    assign b_inv    = ~b;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign d[i]       = a[i] ^ b_inv[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b_inv[i]) | (carry[i] & (a[i] ^ b_inv[i]));
    end

    assign cout = carry[W];

endmodule

// File: rtl/sub_arbiter.sv
// -----------------------------------------------------------------------------
// sub_arbiter
// Round-robin arbiter and sequencer sharing one sub_core among N_REQ
// requesters. Each operation takes IDLE -> CALC -> RESP (3 cycles).
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : sub_arbiter_if.slave (req, a_in, b_in in; gnt, D, Cout,
//           rsp_valid, rsp_id, busy out)
// Build option SUB_ARB_SAT_EN: when defined, a borrowing subtraction
// (Cout=0) returns D=0 instead of the wrapped result; Cout is unchanged.
// -----------------------------------------------------------------------------
module sub_arbiter
    import sub_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int W     = W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    sub_arbiter_if.slave    bus
);

    localparam int ID_W = id_w(N_REQ);

    state_t            state;
    state_t            state_next;
    logic              load;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   id_q;
    logic [ID_W-1:0]   win;
    logic              found;
    logic [W-1:0]      op_a;
    logic [W-1:0]      op_b;
    logic [N_REQ-1:0]  gnt_q;
    logic [W-1:0]      d_q;
    logic              cout_q;
    logic              rsp_valid_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic [W-1:0]      core_d;
    logic              core_cout;
    logic [W-1:0]      d_next;

    sub_core #(.W(W)) u_core (
        .a    (op_a),
        .b    (op_b),
        .d    (core_d),
        .cout (core_cout)
    );

`ifdef SUB_ARB_SAT_EN
    assign d_next = core_cout ? core_d : '0;
`else
    assign d_next = core_d;
`endif

    // Round-robin search: first asserted request at or above ptr, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && bus.req[(int'(ptr) + k) % N_REQ]) begin
                found = 1'b1;
                win   = ID_W'((int'(ptr) + k) % N_REQ);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Requests are only looked at in IDLE; CALC and RESP always advance.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_next = CALC;
                    load       = 1'b1;
                end
            end
            CALC:    state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, grant pulse, result registers and pointer update.
    // The pointer moves past the served requester only once its response
    // is out, so a reset during CALC leaves no trace of the operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr         <= '0;
            id_q        <= '0;
            op_a        <= '0;
            op_b        <= '0;
            gnt_q       <= '0;
            d_q         <= '0;
            cout_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            gnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            if (load) begin
                op_a  <= bus.a_in[int'(win)*W +: W];
                op_b  <= bus.b_in[int'(win)*W +: W];
                id_q  <= win;
                gnt_q <= N_REQ'(1) << win;
            end
            if (state == CALC) begin
                d_q         <= d_next;
                cout_q      <= core_cout;
                rsp_valid_q <= 1'b1;
                rsp_id_q    <= id_q;
            end
            if (state == RESP) begin
                ptr <= (int'(id_q) == N_REQ - 1) ? '0 : id_q + 1'b1;
            end
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.D         = d_q;
    assign bus.Cout      = cout_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_sub_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sub_arbiter
// Self-checking bench for sub_arbiter (N_REQ=4, W=5). A behavioural model
// predicts every grant and response; a monitor compares them with the DUT.
// Directed scenarios are followed by a randomized requester phase.
// Honors SUB_ARB_SAT_EN for expected borrow results.
// -----------------------------------------------------------------------------
module tb_sub_arbiter;

    localparam int N = 4;
    localparam int W = 5;

    typedef struct {
        int id;
        int d;
        int c;
        int cyc;
    } exp_t;

    logic clk;
    logic rst_n;

    sub_arbiter_if #(.N_REQ(N), .W(W)) bus ();

    sub_arbiter #(.N_REQ(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   m_ptr = 0;
    int   next_free = 0;
    int   grant_edge = -10;
    exp_t gq[$];
    exp_t rq[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] r, input logic [N*W-1:0] a,
                                 input logic [N*W-1:0] b);
        bus.req  = r;
        bus.a_in = a;
        bus.b_in = b;
    endtask

    // Expected difference from plain integer arithmetic.
    function automatic int refD(input int a, input int b);
        int diff;
        diff = a - b;
`ifdef SUB_ARB_SAT_EN
        if (diff < 0) return 0;
`endif
        return diff & ((1 << W) - 1);
    endfunction

    task automatic applyReset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        applyStimulus('0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic expectNextGnt(input string name, input logic [N-1:0] exp_gnt,
                                 input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bus.gnt != '0) seen = 1'b1;
        end
        if (!seen) checkOutput({name, "_timeout"}, 0, 32'(exp_gnt));
        else       checkOutput(name, 32'(bus.gnt), 32'(exp_gnt));
    endtask

    // Reference model: serves requests one at a time, 3 cycles each,
    // choosing the first requester at or after the pointer.
    task automatic modelLoop();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_ptr      = 0;
                next_free  = 0;
                grant_edge = -10;
                gq.delete();
                rq.delete();
            end else begin
                cyc++;
                if (cyc >= next_free && bus.req != '0) begin
                    int   w;
                    int   a;
                    int   b;
                    exp_t e;
                    w = -1;
                    for (int k = 0; k < N; k++) begin
                        if (w < 0 && bus.req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                    end
                    a = int'(bus.a_in[w*W +: W]);
                    b = int'(bus.b_in[w*W +: W]);
                    e.id  = w;
                    e.d   = refD(a, b);
                    e.c   = (a >= b) ? 1 : 0;
                    e.cyc = cyc;
                    gq.push_back(e);
                    e.cyc = cyc + 1;
                    rq.push_back(e);
                    grant_edge = cyc;
                    next_free  = cyc + 3;
                    m_ptr      = (w + 1) % N;
                end
            end
        end
    endtask

    task automatic monitorLoop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                checkOutput("sb_busy", 32'(bus.busy),
                            (cyc == grant_edge || cyc == grant_edge + 1) ? 1 : 0);
                if (bus.gnt != '0 || (gq.size() > 0 && gq[0].cyc <= cyc)) begin
                    if (gq.size() == 0) begin
                        checkOutput("sb_gnt_extra", 32'(bus.gnt), 0);
                    end else begin
                        e = gq.pop_front();
                        checkOutput("sb_gnt", 32'(bus.gnt), 32'(1) << e.id);
                        checkOutput("sb_gnt_cycle", cyc, e.cyc);
                    end
                end
                if (bus.rsp_valid || (rq.size() > 0 && rq[0].cyc <= cyc)) begin
                    if (rq.size() == 0) begin
                        checkOutput("sb_rsp_extra", 32'(bus.rsp_valid), 0);
                    end else begin
                        e = rq.pop_front();
                        checkOutput("sb_rsp_valid", 32'(bus.rsp_valid), 1);
                        checkOutput("sb_rsp_id", 32'(bus.rsp_id), e.id);
                        checkOutput("sb_D", 32'(bus.D), e.d);
                        checkOutput("sb_Cout", 32'(bus.Cout), e.c);
                        checkOutput("sb_rsp_cycle", cyc, e.cyc);
                    end
                end
            end
        end
    endtask

    // Random requesters: raise with fresh operands, hold until granted,
    // then release; occasionally give up before winning.
    task automatic randomPhase(input int n_cycles);
        bit pend [N];
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        for (int c = 0; c < n_cycles; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (pend[i]) begin
                    if (bus.gnt[i]) begin
                        pend[i]    = 1'b0;
                        bus.req[i] = 1'b0;
                    end else if ($urandom_range(0, 39) == 0) begin
                        pend[i]    = 1'b0;
                        bus.req[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    bus.a_in[i*W +: W] = W'($urandom_range(0, (1 << W) - 1));
                    if ($urandom_range(0, 7) == 0) bus.b_in[i*W +: W] = bus.a_in[i*W +: W];
                    else bus.b_in[i*W +: W] = W'($urandom_range(0, (1 << W) - 1));
                    bus.req[i] = 1'b1;
                    pend[i]    = 1'b1;
                end
            end
        end
        applyStimulus('0, bus.a_in, bus.b_in);
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus('0, '0, '0);
        fork
            modelLoop();
            monitorLoop();
            begin
                #1000000;
                $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
                $fatal(1, "[TB] watchdog expired");
            end
        join_none

        // Reset values
        applyReset();
        @(negedge clk);
        checkOutput("rst_gnt", 32'(bus.gnt), 0);
        checkOutput("rst_D", 32'(bus.D), 0);
        checkOutput("rst_Cout", 32'(bus.Cout), 0);
        checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        checkOutput("rst_rsp_id", 32'(bus.rsp_id), 0);
        checkOutput("rst_busy", 32'(bus.busy), 0);

        // Single request from requester 2: 9 - 4
        applyStimulus(4'b0100, 20'(9) << 10, 20'(4) << 10);
        @(negedge clk);
        checkOutput("single_gnt", 32'(bus.gnt), 4);
        checkOutput("single_busy", 32'(bus.busy), 1);
        applyStimulus('0, '0, '0);
        @(negedge clk);
        checkOutput("single_valid", 32'(bus.rsp_valid), 1);
        checkOutput("single_D", 32'(bus.D), 5);
        checkOutput("single_Cout", 32'(bus.Cout), 1);
        checkOutput("single_id", 32'(bus.rsp_id), 2);
        @(negedge clk);
        checkOutput("single_valid_drop", 32'(bus.rsp_valid), 0);
        checkOutput("single_D_hold", 32'(bus.D), 5);
        checkOutput("single_id_hold", 32'(bus.rsp_id), 2);
        checkOutput("single_idle", 32'(bus.busy), 0);

        // Borrow: 3 - 5 on requester 0
        applyStimulus(4'b0001, 20'(3), 20'(5));
        expectNextGnt("borrow_gnt", 4'b0001, 6);
        applyStimulus('0, '0, '0);
        @(negedge clk);
`ifdef SUB_ARB_SAT_EN
        checkOutput("borrow_D", 32'(bus.D), 0);
`else
        checkOutput("borrow_D", 32'(bus.D), 30);
`endif
        checkOutput("borrow_Cout", 32'(bus.Cout), 0);

        // Equal operands on requester 1: 17 - 17
        @(negedge clk);
        applyStimulus(4'b0010, 20'(17) << 5, 20'(17) << 5);
        expectNextGnt("equal_gnt", 4'b0010, 6);
        applyStimulus('0, '0, '0);
        @(negedge clk);
        checkOutput("equal_D", 32'(bus.D), 0);
        checkOutput("equal_Cout", 32'(bus.Cout), 1);

        // Contention: all four held for 12 cycles after reset
        applyReset();
        @(negedge clk);
        applyStimulus(4'b1111, {5'd20, 5'd3, 5'd15, 5'd7}, {5'd1, 5'd9, 5'd15, 5'd2});
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            checkOutput($sformatf("contend_gnt_%0d", n), 32'(bus.gnt),
                        (n % 3 == 1) ? (32'(1) << (n / 3)) : 0);
        end
        applyStimulus('0, '0, '0);

        // Fairness: serve id 1, then 0 and 1 compete with pointer at 2
        applyReset();
        @(negedge clk);
        applyStimulus(4'b0010, 20'(6) << 5, 20'(2) << 5);
        expectNextGnt("fair_first", 4'b0010, 6);
        applyStimulus('0, '0, '0);
        @(negedge clk);
        applyStimulus(4'b0011, {10'd0, 5'd8, 5'd11}, {10'd0, 5'd12, 5'd1});
        expectNextGnt("fair_wrap_to_0", 4'b0001, 6);
        bus.req[0] = 1'b0;
        expectNextGnt("fair_then_1", 4'b0010, 6);
        applyStimulus('0, '0, '0);
        repeat (2) @(negedge clk);

        // Reset during CALC drops the operation and clears the pointer
        applyStimulus(4'b1000, 20'(7) << 15, 20'(2) << 15);
        expectNextGnt("midrst_gnt", 4'b1000, 6);
        #2 rst_n = 1'b0;
        applyStimulus('0, '0, '0);
        #1;
        checkOutput("midrst_gnt_clr", 32'(bus.gnt), 0);
        checkOutput("midrst_busy_clr", 32'(bus.busy), 0);
        checkOutput("midrst_D_clr", 32'(bus.D), 0);
        checkOutput("midrst_Cout_clr", 32'(bus.Cout), 0);
        checkOutput("midrst_id_clr", 32'(bus.rsp_id), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            checkOutput("midrst_no_rsp", 32'(bus.rsp_valid), 0);
        end
        applyStimulus(4'b1010, {5'd4, 5'd0, 5'd9, 5'd0}, {5'd1, 5'd0, 5'd3, 5'd0});
        expectNextGnt("midrst_ptr0", 4'b0010, 6);
        applyStimulus('0, '0, '0);
        repeat (4) @(negedge clk);

        // Randomized requesters
        randomPhase(1500);
        repeat (8) @(negedge clk);
        checkOutput("drain_gnt_queue", gq.size(), 0);
        checkOutput("drain_rsp_queue", rq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
